// File: rtl/mem_arbiter_if.sv
// Bus bundle between the mem_arbiter, its two requesters (CPU, DMA/video) and the RAM.
// The arbiter takes the slave view; the requesters and RAM together take the master view.
interface mem_arbiter_if;
  logic        cpu_req;
  logic [15:0] cpu_address;
  logic        cpu_we;
  logic [7:0]  cpu_data_o;
  logic        cpu_ack;
  logic [7:0]  cpu_data_i;

  logic        dma_req;
  logic [15:0] dma_address;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;

  logic [15:0] mem_address;
  logic [7:0]  mem_data_o;
  logic        mem_we;
  logic [7:0]  mem_data_i;

  modport slave (
    input  cpu_req, cpu_address, cpu_we, cpu_data_o,
    input  dma_req, dma_address, dma_we, dma_wdata,
    input  mem_data_i,
    output cpu_ack, cpu_data_i, dma_ack, dma_rdata,
    output mem_address, mem_data_o, mem_we
  );

  modport master (
    output cpu_req, cpu_address, cpu_we, cpu_data_o,
    output dma_req, dma_address, dma_we, dma_wdata,
    output mem_data_i,
    input  cpu_ack, cpu_data_i, dma_ack, dma_rdata,
    input  mem_address, mem_data_o, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port synchronous RAM with registered reads.
// Each access is ACC (address/we to RAM) then DONE (ack + read data); CPU tie wins are bounded by a run counter.
module mem_arbiter #(
  parameter int unsigned CPU_RUN_MAX = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
  typedef enum logic       {OWN_CPU, OWN_DMA}      owner_t;

  localparam logic [3:0] RUN_MAX = 4'(CPU_RUN_MAX);

  state_t      r_state;
  owner_t      r_owner;
  logic [3:0]  r_run;
  logic [15:0] r_address;
  logic [7:0]  r_wdata;
  logic        r_we;
  logic [7:0]  r_cpu_hold;
  logic [7:0]  r_dma_hold;

  state_t      w_state_next;
  logic        w_grant;
  logic        w_grant_dma;
  logic        w_tied;
  logic        w_ack_cpu;
  logic        w_ack_dma;
  logic [3:0]  w_run_next;

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = S_IDLE;
    w_grant      = 1'b0;
    w_grant_dma  = 1'b0;
    w_tied       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req && bus.dma_req) begin
          w_grant     = 1'b1;
          w_tied      = 1'b1;
          w_grant_dma = (r_run >= RUN_MAX);
        end else if (bus.cpu_req) begin
          w_grant = 1'b1;
        end else if (bus.dma_req) begin
          w_grant     = 1'b1;
          w_grant_dma = 1'b1;
        end
      end
      S_DONE: begin
        // The owner's req is stale in its ack cycle; only the other port may be granted back-to-back.
        if (r_owner == OWN_CPU) begin
          w_grant     = bus.dma_req;
          w_grant_dma = bus.dma_req;
        end else begin
          w_grant = bus.cpu_req;
        end
      end
      default: ;
    endcase

    if (w_grant)
      w_state_next = S_ACC;
    else if (r_state == S_ACC)
      w_state_next = S_DONE;
  end

  always_comb begin
    w_run_next = r_run;
    if (w_grant && w_grant_dma)
      w_run_next = 4'd0;
    else if (w_grant && w_tied && (r_run != 4'hF))
      w_run_next = r_run + 4'd1;
  end

  assign w_ack_cpu = (r_state == S_DONE) && (r_owner == OWN_CPU);
  assign w_ack_dma = (r_state == S_DONE) && (r_owner == OWN_DMA);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_CPU;
      r_run      <= 4'd0;
      r_address  <= 16'h0000;
      r_wdata    <= 8'h00;
      r_we       <= 1'b0;
      r_cpu_hold <= 8'h00;
      r_dma_hold <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
      if (w_grant) begin
        r_owner   <= w_grant_dma ? OWN_DMA : OWN_CPU;
        r_address <= w_grant_dma ? bus.dma_address : bus.cpu_address;
        r_wdata   <= w_grant_dma ? bus.dma_wdata   : bus.cpu_data_o;
        r_we      <= w_grant_dma ? bus.dma_we      : bus.cpu_we;
      end
      if (w_ack_cpu && !r_we)
        r_cpu_hold <= bus.mem_data_i;
      if (w_ack_dma && !r_we)
        r_dma_hold <= bus.mem_data_i;
    end
  end

  assign bus.mem_address = r_address;
  assign bus.mem_data_o  = r_wdata;
  assign bus.mem_we      = (r_state == S_ACC) && r_we;

  assign bus.cpu_ack    = w_ack_cpu;
  assign bus.dma_ack    = w_ack_dma;
  assign bus.cpu_data_i = (w_ack_cpu && !r_we) ? bus.mem_data_i : r_cpu_hold;
  assign bus.dma_rdata  = (w_ack_dma && !r_we) ? bus.mem_data_i : r_dma_hold;

endmodule
